freq_meter: RTL and testbench

- Measures the frequency of an asynchronous slow input, for example a divided 1 Hz tick or an alarm buzzer drive.
- Counts rising edges of that input over a fixed gate window of GATE_CYCLES system clocks.
- Reports the count with a one-cycle valid pulse.
- Acts as the checking end of the clock-divider chain: the divider turns the system clock into a slow clock, and this block turns a slow clock back into a number. It is used for self-test of divided clocks and for display of measured rates.

---
 rtl/freq_meter.sv | 122 ++++++++++++
 tb/tb_freq_meter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of an asynchronous sig_in over a GATE_CYCLES window of cin.
// Optional FREQ_METER_CONT_EN: free-running back-to-back windows after a single start.
module freq_meter #(
  parameter int GATE_CYCLES = 50000000,
  parameter int CNT_W       = 28
) (
  input  logic             cin,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sig_in,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam int GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] LAST = GW'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    GATE,
    DONE
  } state_t;

  state_t           state;
  logic             s1;
  logic             s2;
  logic             s3;
  logic             rise;
  logic [GW-1:0]    gate_cnt;
  logic [CNT_W-1:0] acc;
  logic [CNT_W-1:0] acc_inc;
  logic             sat;
  logic             sat_inc;

  assign rise = s2 & ~s3;

  // Saturating accumulate: once all-ones, further rises only raise the flag.
  always_comb begin
    acc_inc = acc;
    sat_inc = sat;
    if (rise) begin
      if (&acc) begin
        sat_inc = 1'b1;
      end else begin
        acc_inc = acc + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge cin) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Results are latched on the last gate edge so they appear together with valid.
  always_ff @(posedge cin) begin
    if (!rst_n) begin
      state    <= IDLE;
      gate_cnt <= '0;
      acc      <= '0;
      sat      <= 1'b0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= GATE;
            gate_cnt <= '0;
            acc      <= '0;
            sat      <= 1'b0;
            busy     <= 1'b1;
          end
        end
        GATE: begin
          gate_cnt <= gate_cnt + GW'(1);
          acc      <= acc_inc;
          sat      <= sat_inc;
          if (gate_cnt == LAST) begin
            state    <= DONE;
            valid    <= 1'b1;
            count    <= acc_inc;
            overflow <= sat_inc;
`ifdef FREQ_METER_CONT_EN
            busy     <= 1'b1;
`else
            busy     <= 1'b0;
`endif
          end
        end
        DONE: begin
`ifdef FREQ_METER_CONT_EN
          // The rise seen in this cycle belongs to the window that starts now.
          state    <= GATE;
          gate_cnt <= '0;
          acc      <= rise ? CNT_W'(1) : '0;
          sat      <= 1'b0;
          busy     <= 1'b1;
`else
          state    <= IDLE;
`endif
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: scoreboard bench for freq_meter; a small-window instance for timing and
// counting, and a long-window instance with a narrow result to exercise saturation.
module tb_freq_meter;

  localparam int G  = 100;
  localparam int GB = 1000;
  localparam int W  = 8;

  logic         cin = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         start_big = 1'b0;
  logic         sig_in = 1'b0;
  logic         busy, valid, overflow;
  logic         busy_big, valid_big, overflow_big;
  logic [W-1:0] count, count_big;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int gen_period = 0;
  bit gen_level = 1'b0;
  int phase = 0;

  typedef struct {
    int exp_count;
    int tol;
    bit exp_ovf;
    int exp_cyc;
  } exp_t;

  typedef struct {
    int period;
    bit level;
    int exp_count;
    int tol;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];

  freq_meter #(.GATE_CYCLES(G), .CNT_W(W)) dut (
    .cin(cin), .rst_n(rst_n), .start(start), .sig_in(sig_in),
    .busy(busy), .valid(valid), .count(count), .overflow(overflow)
  );

  freq_meter #(.GATE_CYCLES(GB), .CNT_W(W)) dut_big (
    .cin(cin), .rst_n(rst_n), .start(start_big), .sig_in(sig_in),
    .busy(busy_big), .valid(valid_big), .count(count_big), .overflow(overflow_big)
  );

  always #5 cin = ~cin;

  always @(posedge cin) cyc++;

  // Square wave of gen_period cycles (high for the first half), or a fixed level when period is 0.
  always @(posedge cin) begin
    #1;
    if (gen_period == 0) begin
      sig_in = gen_level;
    end else begin
      sig_in = (phase < gen_period / 2);
      phase = (phase + 1) % gen_period;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected, input int tol);
    int diff;
    checks++;
    diff = actual - expected;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (tol %0d) at cycle %0d", name, actual, expected, tol, cyc);
    end
  endtask

  // Scoreboard consumer: every valid pulse must match the oldest pending expectation.
  always @(negedge cin) begin
    exp_t e;
    if (!rst_n) busy_cnt = 0;
    else if (busy) busy_cnt++;
    if (valid) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_valid", 1, 0, 0);
      end else begin
        e = sb.pop_front();
        checkOutput("count", int'(count), e.exp_count, e.tol);
        checkOutput("overflow", int'(overflow), int'(e.exp_ovf), 0);
        checkOutput("latency", cyc, e.exp_cyc, 0);
        checkOutput("busy_in_done", int'(busy), 0, 0);
        checkOutput("busy_cycles", busy_cnt, G, 0);
      end
      busy_cnt = 0;
    end
  end

  task automatic setSig(input int p, input bit lvl);
    gen_period = p;
    gen_level  = lvl;
    phase      = 0;
    repeat (6) @(negedge cin);
  endtask

  task automatic applyStimulus(input int exp_count, input int tol, input bit exp_ovf);
    exp_t e;
    @(negedge cin);
    start = 1'b1;
    @(negedge cin);
    start = 1'b0;
    e.exp_count = exp_count;
    e.tol       = tol;
    e.exp_ovf   = exp_ovf;
    e.exp_cyc   = cyc + G;
    sb.push_back(e);
    checkOutput("busy_after_start", int'(busy), 1, 0);
  endtask

  task automatic waitIdle(input int bound);
    int n = 0;
    while (sb.size() > 0 && n < bound) begin
      @(negedge cin);
      n++;
    end
    checkOutput("done_in_time", sb.size(), 0, 0);
    sb.delete();
  endtask

  task automatic runBig(input int p, input int exp_count, input int tol, input bit exp_ovf);
    int n = 0;
    setSig(p, 1'b0);
    @(negedge cin);
    start_big = 1'b1;
    @(negedge cin);
    start_big = 1'b0;
    while (!valid_big && n < GB + 20) begin
      @(negedge cin);
      n++;
    end
    checkOutput("big_valid_seen", int'(valid_big), 1, 0);
    checkOutput("big_count", int'(count_big), exp_count, tol);
    checkOutput("big_overflow", int'(overflow_big), int'(exp_ovf), 0);
  endtask

  initial begin
    int e0;
    int n;
    int vseen;
    exp_t e;

    vecs = '{'{10, 1'b0, 10, 1}, '{0, 1'b0, 0, 0}, '{0, 1'b1, 0, 0},
             '{4, 1'b0, 25, 1}, '{2, 1'b0, 50, 1}, '{20, 1'b0, 5, 1}};

    rst_n = 1'b0;
    repeat (3) @(negedge cin);
    checkOutput("reset_busy", int'(busy), 0, 0);
    checkOutput("reset_valid", int'(valid), 0, 0);
    checkOutput("reset_count", int'(count), 0, 0);
    checkOutput("reset_overflow", int'(overflow), 0, 0);
    checkOutput("reset_big_busy", int'(busy_big), 0, 0);
    checkOutput("reset_big_count", int'(count_big), 0, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge cin);

    for (int i = 0; i < 6; i++) begin
      setSig(vecs[i].period, vecs[i].level);
      applyStimulus(vecs[i].exp_count, vecs[i].tol, 1'b0);
      waitIdle(G + 20);
      repeat (2) @(negedge cin);
    end

    repeat (20) @(negedge cin);
    checkOutput("count_hold", int'(count), 5, 1);
    checkOutput("valid_idle", int'(valid), 0, 0);

    // A start while busy must be dropped, not queued.
    setSig(10, 1'b0);
    applyStimulus(10, 1, 1'b0);
    repeat (30) @(negedge cin);
    start = 1'b1;
    @(negedge cin);
    start = 1'b0;
    waitIdle(G + 20);
    repeat (G + 10) @(negedge cin);

    // Held start: three windows spaced G+2 cycles apart.
    setSig(4, 1'b0);
    @(negedge cin);
    start = 1'b1;
    @(negedge cin);
    e0 = cyc;
    for (int k = 0; k < 3; k++) begin
      e.exp_count = 25;
      e.tol       = 1;
      e.exp_ovf   = 1'b0;
      e.exp_cyc   = e0 + G + k * (G + 2);
      sb.push_back(e);
    end
    n = 0;
    while (sb.size() > 1 && n < 3 * G) begin
      @(negedge cin);
      n++;
    end
    checkOutput("two_windows_in_time", sb.size(), 1, 0);
    repeat (10) @(negedge cin);
    start = 1'b0;
    waitIdle(G + 20);
    repeat (G + 10) @(negedge cin);

    // Reset in the middle of a window aborts it silently.
    setSig(10, 1'b0);
    @(negedge cin);
    start = 1'b1;
    @(negedge cin);
    start = 1'b0;
    repeat (49) @(negedge cin);
    rst_n = 1'b0;
    @(negedge cin);
    rst_n = 1'b1;
    checkOutput("abort_busy", int'(busy), 0, 0);
    checkOutput("abort_valid", int'(valid), 0, 0);
    checkOutput("abort_count", int'(count), 0, 0);
    checkOutput("abort_overflow", int'(overflow), 0, 0);
    vseen = 0;
    repeat (G + 10) begin
      @(negedge cin);
      if (valid) vseen++;
    end
    checkOutput("no_valid_after_abort", vseen, 0, 0);
    applyStimulus(10, 1, 1'b0);
    waitIdle(G + 20);

    // Long window: period 2 saturates an 8-bit count, then a normal window clears the flag.
    runBig(2, 255, 0, 1'b1);
    runBig(10, 100, 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
